// File: rtl/online_otf_converter.sv
// online_otf_converter: digit-serial on-the-fly conversion of a borrow-save
// online word (MSD first) into a two's-complement integer using the Q/QM
// register pair. One word is in flight at a time.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its data and keeps valid
// high until that edge. Ready never depends combinationally on valid.
module online_otf_converter #(
  parameter  int DIGITS = 20,
  localparam int WL_IN  = 2 * DIGITS,
  localparam int WL_OUT = DIGITS + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WL_IN-1:0]  din,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WL_OUT-1:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WL_IN-1:0]   sr, sr_nxt;
  logic [WL_OUT-1:0]  q, q_nxt;
  logic [WL_OUT-1:0]  qm, qm_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WL_OUT-1:0]  dout_nxt;
  logic [1:0]         digit;

  // Current digit is always the top two bits of the shift register.
  assign digit = sr[WL_IN-1 -: 2];

  // Outputs decoded from registered state.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Next-state and datapath update. QM tracks Q-1 so a -1 digit can pick
  // its new Q from QM instead of propagating a borrow.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    q_nxt     = q;
    qm_nxt    = qm;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sr_nxt    = din;
          q_nxt     = '0;
          qm_nxt    = '1;
          cnt_nxt   = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (enable) begin
          case (digit)
            2'b10: begin  // +1
              q_nxt  = {q[WL_OUT-2:0], 1'b1};
              qm_nxt = {q[WL_OUT-2:0], 1'b0};
            end
            2'b01: begin  // -1
              q_nxt  = {qm[WL_OUT-2:0], 1'b1};
              qm_nxt = {qm[WL_OUT-2:0], 1'b0};
            end
            default: begin  // 0 (00 or 11)
              q_nxt  = {q[WL_OUT-2:0], 1'b0};
              qm_nxt = {qm[WL_OUT-2:0], 1'b1};
            end
          endcase
          sr_nxt  = {sr[WL_IN-3:0], 2'b00};
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            dout_nxt  = q_nxt;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      q         <= q_nxt;
      qm        <= qm_nxt;
      cnt       <= cnt_nxt;
      dout      <= dout_nxt;
      out_valid <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// Bench for online_otf_converter: table of directed words, random words
// checked against a digit-sum model, and sequences for backpressure,
// enable stalls and mid-conversion reset.
module tb_online_otf_converter;

  localparam int DIGITS = 20;
  localparam int WL_IN  = 2 * DIGITS;
  localparam int WL_OUT = DIGITS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [WL_IN-1:0]  din = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WL_OUT-1:0] dout;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [1:0]        state_dbg;

  int tests = 0;
  int fails = 0;
  logic [WL_OUT-1:0] exp_q[$];
  logic [WL_OUT-1:0] last_exp;

  typedef struct {
    logic [WL_IN-1:0]  din;
    logic [WL_OUT-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  online_otf_converter #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: direct sum of signed digits times powers of two.
  function automatic logic [WL_OUT-1:0] model(input logic [WL_IN-1:0] w);
    longint v;
    v = 0;
    for (int i = 0; i < DIGITS; i++)
      v = v + (longint'(w[2*i+1]) - longint'(w[2*i])) * (longint'(1) << i);
    return v[WL_OUT-1:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a word until accepted; expected result goes to the scoreboard.
  task automatic send(input logic [WL_IN-1:0] w, input logic [WL_OUT-1:0] e);
    int n;
    @(negedge clk);
    din = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Called just after the accepting edge. Counts cycles to out_valid,
  // optionally stalling enable for 3 cycles starting at cycle drop_at.
  task automatic wait_out(input int drop_at, input int exp_lat);
    int cyc;
    logic bad;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    bad = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready || !busy) bad = 1'b1;
      if (cyc == drop_at) enable = 1'b0;
      if (cyc == drop_at + 3) enable = 1'b1;
      @(negedge clk);
      cyc++;
    end
    enable = 1'b1;
    check("conv_in_ready_busy", bad, 1'b0);
    check("out_valid", out_valid, 1'b1);
    check("latency", cyc, exp_lat);
    check("hold_in_ready", in_ready, 1'b0);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got output %0h, expected queue empty", dout);
    end else begin
      last_exp = exp_q.pop_front();
      check("dout", dout, last_exp);
    end
  endtask

  // Accept the output and confirm the return to IDLE.
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_out_valid", out_valid, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_busy", busy, 1'b0);
  endtask

  initial begin
    logic [WL_IN-1:0] w;
    logic [WL_IN-1:0] wb;
    logic [WL_IN-1:0] pat;
    logic bad;

    tbl[0].din = '0;                      tbl[0].exp = 21'h000000;
    pat = '0; pat[39] = 1'b1;
    tbl[1].din = pat;                     tbl[1].exp = 21'h080000;
    tbl[2].din = {DIGITS{2'b01}};         tbl[2].exp = 21'h100001;
    tbl[3].din = '1;                      tbl[3].exp = 21'h000000;
    pat = '0; pat[3:0] = 4'b0110;
    tbl[4].din = pat;                     tbl[4].exp = 21'h1FFFFF;
    pat = '0; pat[39] = 1'b1; pat[0] = 1'b1;
    tbl[5].din = pat;                     tbl[5].exp = 21'h07FFFF;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 2'd0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].din, tbl[i].exp);
      wait_out(-1, DIGITS + 1);
      release_out();
    end

    // random words against the model
    for (int i = 0; i < 8; i++) begin
      w = {$urandom(), $urandom()};
      send(w, model(w));
      wait_out(-1, DIGITS + 1);
      release_out();
    end

    // output backpressure with a competing input word
    w  = {$urandom(), $urandom()};
    wb = {$urandom(), $urandom()};
    send(w, model(w));
    wait_out(-1, DIGITS + 1);
    @(negedge clk);
    din = wb;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (dout !== last_exp || in_ready || !out_valid || !busy) bad = 1'b1;
      @(negedge clk);
    end
    check("hold_stable", bad, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_rel_out_valid", out_valid, 1'b0);
    check("hold_rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(model(wb));
    wait_out(-1, DIGITS + 1);
    release_out();

    // enable stall of 3 cycles mid-conversion
    w = {$urandom(), $urandom()};
    send(w, model(w));
    wait_out(5, DIGITS + 4);
    release_out();

    // reset at cycle 10 of a conversion
    send(tbl[1].din, tbl[1].exp);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_dout", dout, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    void'(exp_q.pop_back());
    send(tbl[5].din, tbl[5].exp);
    wait_out(-1, DIGITS + 1);
    release_out();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
